// File: rtl/display_pio_sched.sv
// Two-requester PIO write scheduler: round-robin arbitration into a FIFO, one issue per frame on
// slot_sync, plus a frame-sync watchdog. Define DISPLAY_PIO_STRICT_PRIO_EN for A-over-B priority.
module display_pio_sched #(
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned SLOT_CYCLES = 100
) (
    input  logic             c125,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [3:0]       a_addr,
    input  logic [7:0]       a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [3:0]       b_addr,
    input  logic [7:0]       b_data,
    input  logic             slot_sync,
    input  logic             fifostat,
    output logic             wvalid,
    output logic [3:0]       waddr,
    output logic [7:0]       wdata,
    output logic [FIFO_AW:0] level,
    output logic             sync_lost,
    input  logic             clr
);

    localparam int unsigned DEPTH    = 1 << FIFO_AW;
    localparam int unsigned WD_LIMIT = 2 * SLOT_CYCLES;
    localparam int unsigned WD_W     = $clog2(WD_LIMIT + 1);

    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [WD_W-1:0]    WD_MAX   = WD_W'(WD_LIMIT);
    localparam logic [WD_W-1:0]    WD_PRE   = WD_W'(WD_LIMIT - 1);
    localparam logic [WD_W-1:0]    WD_ONE   = WD_W'(1);

    logic [11:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_level;
    logic [WD_W-1:0]    r_wd_cnt;
    logic               r_sync_lost;
    logic               r_wvalid;
    logic [3:0]         r_waddr;
    logic [7:0]         r_wdata;

    logic               w_full;
    logic               w_empty;
    logic               w_issue;
    logic               w_space;
    logic               w_grant_a;
    logic               w_grant_b;
    logic               w_accept_a;
    logic               w_accept_b;
    logic               w_push;
    logic [11:0]        w_wentry;

    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);

    // Read decision is combinational so the dequeue frees a slot on the same edge.
    assign w_issue = slot_sync & ~w_empty & ~fifostat & ~r_sync_lost & ~clr;
    assign w_space = ~w_full | w_issue;

`ifdef DISPLAY_PIO_STRICT_PRIO_EN
    always_comb begin
        w_grant_a = a_valid;
        w_grant_b = b_valid & ~a_valid;
    end
`else
    // r_ptr_b = 1 means B is preferred when both requesters are valid.
    logic r_ptr_b;

    always_comb begin
        w_grant_a = a_valid;
        w_grant_b = b_valid;
        if (a_valid && b_valid) begin
            w_grant_a = ~r_ptr_b;
            w_grant_b = r_ptr_b;
        end
    end

    always_ff @(posedge c125 or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr_b <= 1'b0;
        end else if (clr) begin
            r_ptr_b <= 1'b0;
        end else if (w_accept_a) begin
            r_ptr_b <= 1'b1;
        end else if (w_accept_b) begin
            r_ptr_b <= 1'b0;
        end
    end
`endif

    // rst_n gates ready so nothing is acknowledged while reset is held.
    assign w_accept_a = w_grant_a & w_space & ~clr & rst_n;
    assign w_accept_b = w_grant_b & w_space & ~clr & rst_n;
    assign w_push     = w_accept_a | w_accept_b;
    assign w_wentry   = w_accept_a ? {a_addr, a_data} : {b_addr, b_data};

    always_ff @(posedge c125) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_wentry;
        end
    end

    always_ff @(posedge c125 or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            unique case ({w_push, w_issue})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge c125 or negedge rst_n) begin
        if (!rst_n) begin
            r_wvalid <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_wvalid <= w_issue;
            if (w_issue) begin
                {r_waddr, r_wdata} <= r_mem[r_rptr];
            end
        end
    end

    // Counter saturates at the limit; sync_lost is sticky until clr.
    always_ff @(posedge c125 or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt    <= '0;
            r_sync_lost <= 1'b0;
        end else if (clr) begin
            r_wd_cnt    <= '0;
            r_sync_lost <= 1'b0;
        end else if (slot_sync) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != WD_MAX) begin
            r_wd_cnt <= r_wd_cnt + WD_ONE;
            if (r_wd_cnt == WD_PRE) begin
                r_sync_lost <= 1'b1;
            end
        end
    end

    assign a_ready   = w_accept_a;
    assign b_ready   = w_accept_b;
    assign wvalid    = r_wvalid;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign level     = r_level;
    assign sync_lost = r_sync_lost;

endmodule
